// File: rtl/mac_bank_sched.sv
// rtl/mac_bank_sched.sv - scheduler and job sequencers for the shared MAC bank
//
// Purpose:
//   Arbitrates the shared MAC region between the conv engine (sel=1) and the
//   fc1 engine (sel=0). Sequences fc2 and fc3 on their private MACs. Each job
//   has the timing gnt@G, clr@G+1, done@G+len+MAC_LAT, and a zero length
//   counts as one operand cycle.
//
// Optional feature:
//   SCHED_FIXPRIO_EN - fixed priority, fc1 beats conv on a tie, no
//                      round-robin pointer. When undefined, a tie goes to
//                      whichever requester was not granted last.
//
// Ports (mac_bank_sched):
//   clk, rst_n                 clock, asynchronous active-low reset
//   conv_req/conv_layer/conv_len   conv job request, layer, operand count
//   fc1_req/fc1_len            fc1 job request (shared region)
//   fc2_req/fc2_len            fc2 job request (private MACs)
//   fc3_req/fc3_len            fc3 job request (private MACs)
//   conv_gnt..fc3_gnt          one-cycle grant pulses
//   sel                        bank mode, 1 = conv, 0 = fc1
//   conv1_clr..fc3_clr         accumulator clear pulses, with operand 0
//   conv_done..fc3_done        one-cycle pulse when the MAC outputs are valid
//   shared_busy                shared region owned, grant through done

// Ports (mac_seq):
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        start a job; only legal while o_ready
//   i_len          operand cycles for the job being started
//   o_ready        idle, or in the done cycle of the current job
//   o_done_nxt     the next cycle is the done cycle
module mac_seq #(
  parameter int LEN_W   = 10,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_ready,
  output logic             o_done_nxt
);
  localparam int CNT_W = LEN_W + 4;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MAC_LAT);

  // r_cnt counts down from len+MAC_LAT in the grant cycle; it reaches 0 in
  // the done cycle, so ACC and DRAIN share a single counter.
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [CNT_W-1:0] w_len_eff;

  assign w_len_eff  = (i_len == '0) ? CNT_W'(1) : CNT_W'(i_len);
  assign o_ready    = !r_busy || (r_cnt == '0);
  assign o_done_nxt = r_busy && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= w_len_eff + LAT_C;
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - CNT_W'(1);
    end
  end
endmodule

module mac_bank_sched #(
  parameter int LEN_W   = 10,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             conv_req,
  input  logic             conv_layer,
  input  logic [LEN_W-1:0] conv_len,
  input  logic             fc1_req,
  input  logic [LEN_W-1:0] fc1_len,
  input  logic             fc2_req,
  input  logic [LEN_W-1:0] fc2_len,
  input  logic             fc3_req,
  input  logic [LEN_W-1:0] fc3_len,
  output logic             conv_gnt,
  output logic             fc1_gnt,
  output logic             fc2_gnt,
  output logic             fc3_gnt,
  output logic             sel,
  output logic             conv1_clr,
  output logic             conv2_clr,
  output logic             fc1_clr,
  output logic             fc2_clr,
  output logic             fc3_clr,
  output logic             conv_done,
  output logic             fc1_done,
  output logic             fc2_done,
  output logic             fc3_done,
  output logic             shared_busy
);
  logic             w_sh_ready, w_sh_done_nxt, w_sh_start, w_pick_conv;
  logic             w_grant_conv, w_grant_fc1;
  logic [LEN_W-1:0] w_sh_len;
  logic             w_fc2_ready, w_fc2_done_nxt, w_fc2_start;
  logic             w_fc3_ready, w_fc3_done_nxt, w_fc3_start;

  logic r_conv_gnt, r_fc1_gnt, r_fc2_gnt, r_fc3_gnt;
  logic r_sel, r_conv_layer, r_shared_busy;
  logic r_conv1_clr, r_conv2_clr, r_fc1_clr, r_fc2_clr, r_fc3_clr;
  logic r_conv_done, r_fc1_done, r_fc2_done, r_fc3_done;

`ifdef SCHED_FIXPRIO_EN
  assign w_pick_conv = conv_req && !fc1_req;
`else
  // r_rr_conv=1: conv takes the next tie (conv was not granted last).
  logic r_rr_conv;
  assign w_pick_conv = conv_req && (!fc1_req || r_rr_conv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_rr_conv <= 1'b1;
    else if (w_sh_start) r_rr_conv <= !w_pick_conv;
  end
`endif

  // In the grant cycle the sequencer is already counting, so a req still
  // high during gnt cannot start a second job.
  assign w_sh_start   = w_sh_ready && (conv_req || fc1_req);
  assign w_grant_conv = w_sh_start && w_pick_conv;
  assign w_grant_fc1  = w_sh_start && !w_pick_conv;
  assign w_sh_len     = w_pick_conv ? conv_len : fc1_len;
  assign w_fc2_start  = fc2_req && w_fc2_ready;
  assign w_fc3_start  = fc3_req && w_fc3_ready;

  mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) u_seq_shared (
    .clk(clk), .rst_n(rst_n), .i_start(w_sh_start), .i_len(w_sh_len),
    .o_ready(w_sh_ready), .o_done_nxt(w_sh_done_nxt)
  );

  mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) u_seq_fc2 (
    .clk(clk), .rst_n(rst_n), .i_start(w_fc2_start), .i_len(fc2_len),
    .o_ready(w_fc2_ready), .o_done_nxt(w_fc2_done_nxt)
  );

  mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) u_seq_fc3 (
    .clk(clk), .rst_n(rst_n), .i_start(w_fc3_start), .i_len(fc3_len),
    .o_ready(w_fc3_ready), .o_done_nxt(w_fc3_done_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_gnt    <= 1'b0;
      r_fc1_gnt     <= 1'b0;
      r_fc2_gnt     <= 1'b0;
      r_fc3_gnt     <= 1'b0;
      r_sel         <= 1'b0;
      r_conv_layer  <= 1'b0;
      r_shared_busy <= 1'b0;
      r_conv1_clr   <= 1'b0;
      r_conv2_clr   <= 1'b0;
      r_fc1_clr     <= 1'b0;
      r_fc2_clr     <= 1'b0;
      r_fc3_clr     <= 1'b0;
      r_conv_done   <= 1'b0;
      r_fc1_done    <= 1'b0;
      r_fc2_done    <= 1'b0;
      r_fc3_done    <= 1'b0;
    end else begin
      r_conv_gnt <= w_grant_conv;
      r_fc1_gnt  <= w_grant_fc1;
      r_fc2_gnt  <= w_fc2_start;
      r_fc3_gnt  <= w_fc3_start;
      if (w_sh_start)   r_sel        <= w_pick_conv;
      if (w_grant_conv) r_conv_layer <= conv_layer;
      // Busy drops after the done cycle unless a back-to-back grant lands.
      r_shared_busy <= w_sh_start || (r_shared_busy && !w_sh_ready);
      // Clears follow the grant by one cycle, aligned with operand 0.
      r_conv1_clr <= r_conv_gnt && !r_conv_layer;
      r_conv2_clr <= r_conv_gnt && r_conv_layer;
      r_fc1_clr   <= r_fc1_gnt;
      r_fc2_clr   <= r_fc2_gnt;
      r_fc3_clr   <= r_fc3_gnt;
      // r_sel still names the owner of the finishing job here; a
      // back-to-back grant only changes it one edge later.
      r_conv_done <= w_sh_done_nxt && r_sel;
      r_fc1_done  <= w_sh_done_nxt && !r_sel;
      r_fc2_done  <= w_fc2_done_nxt;
      r_fc3_done  <= w_fc3_done_nxt;
    end
  end

  assign conv_gnt    = r_conv_gnt;
  assign fc1_gnt     = r_fc1_gnt;
  assign fc2_gnt     = r_fc2_gnt;
  assign fc3_gnt     = r_fc3_gnt;
  assign sel         = r_sel;
  assign conv1_clr   = r_conv1_clr;
  assign conv2_clr   = r_conv2_clr;
  assign fc1_clr     = r_fc1_clr;
  assign fc2_clr     = r_fc2_clr;
  assign fc3_clr     = r_fc3_clr;
  assign conv_done   = r_conv_done;
  assign fc1_done    = r_fc1_done;
  assign fc2_done    = r_fc2_done;
  assign fc3_done    = r_fc3_done;
  assign shared_busy = r_shared_busy;
endmodule

// File: tb/tb_mac_bank_sched.sv
// tb/tb_mac_bank_sched.sv - scoreboard bench for mac_bank_sched
module tb_mac_bank_sched;
  localparam int LEN_W   = 10;
  localparam int MAC_LAT = 3;
  localparam int NSIG    = 13;
  localparam int K_CONV = 0, K_FC1 = 1, K_FC2 = 2, K_FC3 = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic conv_req = 1'b0, conv_layer = 1'b0, fc1_req = 1'b0, fc2_req = 1'b0, fc3_req = 1'b0;
  logic [LEN_W-1:0] conv_len = '0, fc1_len = '0, fc2_len = '0, fc3_len = '0;
  logic conv_gnt, fc1_gnt, fc2_gnt, fc3_gnt, sel, shared_busy;
  logic conv1_clr, conv2_clr, fc1_clr, fc2_clr, fc3_clr;
  logic conv_done, fc1_done, fc2_done, fc3_done;

  mac_bank_sched #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .conv_req(conv_req), .conv_layer(conv_layer), .conv_len(conv_len),
    .fc1_req(fc1_req), .fc1_len(fc1_len), .fc2_req(fc2_req), .fc2_len(fc2_len),
    .fc3_req(fc3_req), .fc3_len(fc3_len),
    .conv_gnt(conv_gnt), .fc1_gnt(fc1_gnt), .fc2_gnt(fc2_gnt), .fc3_gnt(fc3_gnt),
    .sel(sel), .conv1_clr(conv1_clr), .conv2_clr(conv2_clr), .fc1_clr(fc1_clr),
    .fc2_clr(fc2_clr), .fc3_clr(fc3_clr), .conv_done(conv_done), .fc1_done(fc1_done),
    .fc2_done(fc2_done), .fc3_done(fc3_done), .shared_busy(shared_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NSIG-1:0] w_pulse;
  assign w_pulse = {fc3_done, fc2_done, fc1_done, conv_done, fc3_clr, fc2_clr, fc1_clr,
                    conv2_clr, conv1_clr, fc3_gnt, fc2_gnt, fc1_gnt, conv_gnt};
  string sig_name [NSIG] = '{"conv_gnt", "fc1_gnt", "fc2_gnt", "fc3_gnt", "conv1_clr",
                             "conv2_clr", "fc1_clr", "fc2_clr", "fc3_clr", "conv_done",
                             "fc1_done", "fc2_done", "fc3_done"};

  typedef struct { int cyc; int sig; } ev_t;
  typedef struct { int g; int d; int sel; } job_t;
  typedef struct { int kind; int layer; int len; int clr_sig; int done_off; } vec_t;

  ev_t  exp_q[$];
  job_t jobs[$];
  int   vectors = 0, miscompares = 0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int len_eff(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  function automatic void add_ev(input int c, input int s);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    exp_q.push_back(e);
  endfunction

  // Expected pulses of one job granted at g; shared jobs also feed sel/busy.
  function automatic int push_exp(input int kind, input int g, input int clr_sig, input int done_off);
    job_t j;
    add_ev(g, kind);
    add_ev(g + 1, clr_sig);
    add_ev(g + done_off, 9 + kind);
    if (kind < 2) begin
      j.g = g;
      j.d = g + done_off;
      j.sel = (kind == K_CONV) ? 1 : 0;
      jobs.push_back(j);
    end
    return g + done_off;
  endfunction

  function automatic int model_sel();
    int best = -1;
    int v = 0;
    foreach (jobs[i]) if (jobs[i].g <= cyc && jobs[i].g > best) begin
      best = jobs[i].g;
      v = jobs[i].sel;
    end
    return v;
  endfunction

  function automatic int model_busy();
    int b = 0;
    foreach (jobs[i]) if (jobs[i].g <= cyc && cyc <= jobs[i].d) b = 1;
    return b;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int s = 0; s < NSIG; s++) begin
          int expv = 0;
          for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc == cyc && exp_q[i].sig == s) begin
              expv = 1;
              exp_q.delete(i);
            end
          if (w_pulse[s] || expv != 0) chk(sig_name[s], int'(w_pulse[s]), expv);
        end
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].cyc < cyc) begin
            chk({sig_name[exp_q[i].sig], " missed"}, 0, 1);
            exp_q.delete(i);
          end
        chk("sel", int'(sel), model_sel());
        chk("shared_busy", int'(shared_busy), model_busy());
      end
    end
  endtask

  task automatic set_req(input int kind, input logic v, input int layer, input int len);
    if (kind == K_CONV) begin conv_req = v; conv_layer = layer[0]; conv_len = LEN_W'(len); end
    else if (kind == K_FC1) begin fc1_req = v; fc1_len = LEN_W'(len); end
    else if (kind == K_FC2) begin fc2_req = v; fc2_len = LEN_W'(len); end
    else begin fc3_req = v; fc3_len = LEN_W'(len); end
  endtask

  // Requester: hold req until its grant, drop it in the cycle after.
  task automatic request(input int kind, input int layer, input int len);
    int   waited = 0;
    logic seen = 1'b0;
    set_req(kind, 1'b1, layer, len);
    while (!seen && waited < 3000) begin
      @(negedge clk);
      seen = w_pulse[kind];
      waited++;
    end
    if (!seen) chk({sig_name[kind], " timeout"}, 0, 1);
    @(posedge clk);
    #1;
    set_req(kind, 1'b0, layer, len);
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("scoreboard drain", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t tbl [9];
  int   c, d1, g_fc1, n, win;
  logic last_conv;

  initial begin
    tbl[0] = '{K_CONV, 1, 150,  5, 153};
    tbl[1] = '{K_CONV, 0, 5,    4, 8};
    tbl[2] = '{K_CONV, 1, 0,    5, 4};
    tbl[3] = '{K_FC1,  0, 1,    6, 4};
    tbl[4] = '{K_FC1,  0, 1023, 6, 1026};
    tbl[5] = '{K_FC2,  0, 120,  7, 123};
    tbl[6] = '{K_FC2,  0, 2,    7, 5};
    tbl[7] = '{K_FC3,  0, 0,    8, 4};
    tbl[8] = '{K_FC3,  0, 84,   8, 87};

    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #2;
    chk("reset pulses", int'(w_pulse), 0);
    chk("reset sel", int'(sel), 0);
    chk("reset shared_busy", int'(shared_busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous conv/fc1 at reset exit, then fc2/fc3 during the fc1 job.
    c = cyc;
`ifdef SCHED_FIXPRIO_EN
    d1 = push_exp(K_FC1, c + 1, 6, 400 + MAC_LAT);
    void'(push_exp(K_CONV, d1 + 1, 4, 25 + MAC_LAT));
    g_fc1 = c + 1;
    last_conv = 1'b1;
`else
    d1 = push_exp(K_CONV, c + 1, 4, 25 + MAC_LAT);
    void'(push_exp(K_FC1, d1 + 1, 6, 400 + MAC_LAT));
    g_fc1 = d1 + 1;
    last_conv = 1'b0;
`endif
    fork
      request(K_CONV, 0, 25);
      request(K_FC1, 0, 400);
    join_none
    wait_cycle(g_fc1 + 10);
    c = cyc;
    void'(push_exp(K_FC2, c + 1, 7, 120 + MAC_LAT));
    void'(push_exp(K_FC3, c + 1, 8, 84 + MAC_LAT));
    fork
      request(K_FC2, 0, 120);
      request(K_FC3, 0, 84);
    join_none
    wait_quiet();

    // Ties: the loser drops its req before being granted, so is ignored.
    for (int r = 0; r < 3; r++) begin
`ifdef SCHED_FIXPRIO_EN
      win = K_FC1;
`else
      win = last_conv ? K_FC1 : K_CONV;
`endif
      c = cyc;
      void'(push_exp(win, c + 1, (win == K_CONV) ? 4 : 6, 2 + MAC_LAT));
      set_req(K_CONV, 1'b1, 0, 2);
      set_req(K_FC1, 1'b1, 0, 2);
      n = 0;
      while (!(conv_gnt || fc1_gnt) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!(conv_gnt || fc1_gnt)) chk("tie grant timeout", 0, 1);
      @(posedge clk);
      #1;
      set_req(K_CONV, 1'b0, 0, 2);
      set_req(K_FC1, 1'b0, 0, 2);
      last_conv = (win == K_CONV);
      wait_quiet();
    end

    // Isolated jobs from the table.
    for (int i = 0; i < 9; i++) begin
      c = cyc;
      void'(push_exp(tbl[i].kind, c + 1, tbl[i].clr_sig, tbl[i].done_off));
      request(tbl[i].kind, tbl[i].layer, tbl[i].len);
      wait_quiet();
    end

    // Asynchronous reset in the middle of a conv ACC phase.
    c = cyc;
    void'(push_exp(K_CONV, c + 1, 5, 100 + MAC_LAT));
    request(K_CONV, 1, 100);
    wait_cycle(c + 21);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset pulses", int'(w_pulse), 0);
    chk("async reset sel", int'(sel), 0);
    chk("async reset shared_busy", int'(shared_busy), 0);
    exp_q.delete();
    jobs.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (110) @(posedge clk);
    #1;
    c = cyc;
    void'(push_exp(K_CONV, c + 1, 4, 7 + MAC_LAT));
    request(K_CONV, 0, 7);
    wait_quiet();

    chk("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
